// File: rtl/hbm_write_collector_if.sv
// HBM write port: registered address/data with a valid/ready handshake.
// The collector drives it through the master modport.
interface hbm_write_collector_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_ready;

    modport master (
        output wr_addr,
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_addr,
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/hbm_write_collector.sv
// Collects per-lane vertex write-back streams into per-lane FIFOs and issues
// them round-robin, one per cycle, to the HBM write port. Lanes cannot stall.
module hbm_write_collector #(
    parameter int EDGE_PIPELINE_NUM = 4,
    parameter int VERTEX_AWIDTH     = 16,
    parameter int VERTEX_DWIDTH     = 32,
    parameter int FIFO_DEPTH        = 8,
    parameter int FIFO_AWIDTH       = 3
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [EDGE_PIPELINE_NUM*VERTEX_AWIDTH-1:0]  lane_addr,
    input  logic [EDGE_PIPELINE_NUM*VERTEX_DWIDTH-1:0]  lane_data,
    input  logic [EDGE_PIPELINE_NUM-1:0]                lane_valid,
    hbm_write_collector_if.master                       wr,
    input  logic                                        clear_stats,
    output logic [EDGE_PIPELINE_NUM-1:0]                overflow,
    output logic [15:0]                                 drop_cnt,
    output logic [31:0]                                 issued_cnt,
    output logic                                        idle
);
    localparam int N  = EDGE_PIPELINE_NUM;
    localparam int AW = VERTEX_AWIDTH;
    localparam int DW = VERTEX_DWIDTH;
    localparam int LW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = FIFO_AWIDTH + 1;

    localparam logic [FIFO_AWIDTH-1:0] PTR_ONE = FIFO_AWIDTH'(1);
    localparam logic [CW-1:0]          CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [LW-1:0]          LANE_LAST = LW'(N - 1);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t                 mem_q    [N][FIFO_DEPTH];
    logic [FIFO_AWIDTH-1:0] wr_ptr_q [N];
    logic [FIFO_AWIDTH-1:0] rd_ptr_q [N];
    logic [CW-1:0]          cnt_q    [N];
    logic [LW-1:0]          rr_ptr_q;

    logic [AW-1:0]          wr_addr_q;
    logic [DW-1:0]          wr_data_q;
    logic                   wr_valid_q;
    logic [N-1:0]           overflow_q;
    logic [15:0]            drop_cnt_q;
    logic [31:0]            issued_cnt_q;

    logic                   slot_free;
    logic                   accepted;
    logic [N-1:0]           nonempty;
    logic                   grant_found;
    logic [LW-1:0]          grant_idx;
    logic [LW-1:0]          cand;
    logic [LW-1:0]          rr_ptr_d;
    logic [N-1:0]           pop;
    logic [N-1:0]           push;
    logic [N-1:0]           drop;
    entry_t                 head;
    logic [15:0]            drop_now;
    logic [15:0]            drop_base;
    logic [16:0]            drop_sum;
    logic [15:0]            drop_cnt_d;
    logic [N-1:0]           overflow_d;

    assign accepted  = wr_valid_q && wr.wr_ready;
    assign slot_free = !wr_valid_q || wr.wr_ready;

    // Round-robin scan on pre-edge occupancy, so a same-edge push is never eligible.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment; a path that leaves one unassigned would infer a latch.
    always_comb begin
        nonempty    = '0;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < N; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
        end
        for (int off = 0; off < N; off++) begin
            cand = LW'((int'(rr_ptr_q) + off) % N);
            if (!grant_found && nonempty[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        rr_ptr_d = (grant_idx == LANE_LAST) ? '0 : grant_idx + LW'(1);
        head     = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    end

    // A full FIFO still accepts a push when its head leaves on the same edge.
    always_comb begin
        pop  = '0;
        push = '0;
        drop = '0;
        for (int i = 0; i < N; i++) begin
            pop[i]  = slot_free && grant_found && (grant_idx == LW'(i));
            push[i] = lane_valid[i] && ((cnt_q[i] != CNT_FULL) || pop[i]);
            drop[i] = lane_valid[i] && !push[i];
        end
    end

    // clear_stats zeroes the base first, so a same-edge drop still registers.
    always_comb begin
        drop_now = '0;
        for (int i = 0; i < N; i++) begin
            drop_now = drop_now + 16'(drop[i]);
        end
        drop_base  = clear_stats ? '0 : drop_cnt_q;
        drop_sum   = {1'b0, drop_base} + {1'b0, drop_now};
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d = (clear_stats ? '0 : overflow_q) | drop;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            rr_ptr_q     <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            overflow_q   <= '0;
            drop_cnt_q   <= '0;
            issued_cnt_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTR_ONE;
                if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTR_ONE;
                cnt_q[i] <= cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
            end
            if (slot_free) begin
                wr_valid_q <= grant_found;
                if (grant_found) begin
                    wr_addr_q <= head.addr;
                    wr_data_q <= head.data;
                    rr_ptr_q  <= rr_ptr_d;
                end
            end
            if (accepted) issued_cnt_q <= issued_cnt_q + 32'd1;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; cnt_q alone decides which
    // entries are live, and leaving it reset-free lets it map to plain RAM.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= '{addr: lane_addr[i*AW +: AW],
                                           data: lane_data[i*DW +: DW]};
            end
        end
    end

    assign wr.wr_addr  = wr_addr_q;
    assign wr.wr_data  = wr_data_q;
    assign wr.wr_valid = wr_valid_q;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;
    assign issued_cnt  = issued_cnt_q;
    assign idle        = (nonempty == '0) && !wr_valid_q;

endmodule
